// File: rtl/product_accumulator_pkg.sv
// Shared types and defaults for the product accumulator.
package prod_acc_pkg;
  localparam int ACC_W_DEF     = 12;
  localparam int MAX_TERMS_DEF = 32;
  localparam int CNT_W         = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder; ovf flags that the true sum did not fit in W bits.
module sat_adder #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    ovf = raw[W];
    sum = raw[W] ? {W{1'b1}} : raw[W-1:0];
  end
endmodule

// File: rtl/product_accumulator.sv
// Sums bursts of 4x4 products with saturation, then holds the result until taken.
module product_accumulator
  import prod_acc_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic [CNT_W-1:0] acc_count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  state_t           state, state_nx;
  logic             accept, take, close;
  logic [ACC_W-1:0] sum_nx;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_nx;

  sat_adder #(.W(ACC_W)) u_add (
    .a   (acc_sum),
    .b   (ACC_W'(prod)),
    .sum (sum_nx),
    .ovf (sum_ovf)
  );

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign cnt_nx    = acc_count + CNT_W'(1);
  // A burst closes on in_last or when this accept fills the last slot.
  assign close     = in_last || (cnt_nx == CNT_W'(MAX_TERMS));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nx = close ? DONE : ACCUM;
      DONE:        if (take)   state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_sum   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        acc_sum   <= '0;
        acc_count <= '0;
        overflow  <= 1'b0;
      end else if (accept) begin
        acc_sum   <= sum_nx;
        acc_count <= cnt_nx;
        overflow  <= overflow | sum_ovf;
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with hand-computed expectations.
module tb_product_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  prod;
  logic        in_valid, in_last, in_ready;
  logic [11:0] acc_sum;
  logic [5:0]  acc_count;
  logic        overflow, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.ACC_W(12), .MAX_TERMS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod      (prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .acc_sum   (acc_sum),
    .acc_count (acc_count),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prod = '0; in_valid = 0; in_last = 0; out_ready = 0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || acc_sum !== 12'd0 || acc_count !== 6'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b sum=%0d cnt=%0d ovf=%b, want 0/0/0/0",
               out_valid, acc_sum, acc_count, overflow);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_short_burst();
    in_valid = 1; in_last = 0; prod = 8'd225;
    step();
    checks++;
    if (acc_sum !== 12'd225 || acc_count !== 6'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_first: got sum=%0d cnt=%0d rdy=%b v=%b want 225/1/1/0",
               acc_sum, acc_count, in_ready, out_valid);
    end
    prod = 8'd10; step();
    prod = 8'd1; in_last = 1; step();
    in_valid = 0; in_last = 0;
    checks++;
    if (out_valid !== 1'b1 || acc_sum !== 12'd236 || acc_count !== 6'd3 ||
        overflow !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_result: got v=%b sum=%0d cnt=%0d ovf=%b rdy=%b want 1/236/3/0/0",
               out_valid, acc_sum, acc_count, overflow, in_ready);
    end
    out_ready = 1; step(); out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || acc_sum !== 12'd0 || acc_count !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_drain: got v=%b sum=%0d cnt=%0d rdy=%b want 0/0/0/1",
               out_valid, acc_sum, acc_count, in_ready);
    end
  endtask

  task automatic test_saturation();
    in_valid = 1; in_last = 0; prod = 8'd225;
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 17) begin
        checks++;
        if (acc_sum !== 12'd4050 || overflow !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sat_18th: got sum=%0d ovf=%b v=%b want 4050/0/0", acc_sum, overflow, out_valid);
        end
      end
      if (i == 18) begin
        checks++;
        if (acc_sum !== 12'd4095 || overflow !== 1'b1 || acc_count !== 6'd19) begin
          errors++;
          $display("FAIL sat_19th: got sum=%0d ovf=%b cnt=%0d want 4095/1/19", acc_sum, overflow, acc_count);
        end
      end
      if (i == 30) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL sat_31st_open: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || acc_sum !== 12'd4095 || acc_count !== 6'd32 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_result: got v=%b sum=%0d cnt=%0d ovf=%b want 1/4095/32/1",
               out_valid, acc_sum, acc_count, overflow);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1; prod = 8'd7; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_sum !== 12'd4095 ||
          acc_count !== 6'd32 || overflow !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b sum=%0d cnt=%0d ovf=%b want 0/1/4095/32/1",
                 i, in_ready, out_valid, acc_sum, acc_count, overflow);
      end
    end
    out_ready = 1; step();
    in_valid = 0; out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || acc_sum !== 12'd0 || acc_count !== 6'd0 ||
        overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b sum=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/1",
               out_valid, acc_sum, acc_count, overflow, in_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    in_valid = 1; in_last = 0; prod = 8'd25;
    step(); step();
    in_valid = 0;
    checks++;
    if (acc_sum !== 12'd50 || acc_count !== 6'd2) begin
      errors++;
      $display("FAIL mid_partial: got sum=%0d cnt=%0d want 50/2", acc_sum, acc_count);
    end
    rst_n = 0; step(); rst_n = 1;
    checks++;
    if (acc_sum !== 12'd0 || acc_count !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got sum=%0d cnt=%0d v=%b rdy=%b want 0/0/0/1",
               acc_sum, acc_count, out_valid, in_ready);
    end
  endtask

  task automatic test_ignored_last();
    in_valid = 0; in_last = 1; prod = 8'd99;
    step(); step();
    in_last = 0;
    checks++;
    if (out_valid !== 1'b0 || acc_count !== 6'd0 || acc_sum !== 12'd0) begin
      errors++;
      $display("FAIL ignored_last: got v=%b cnt=%0d sum=%0d want 0/0/0", out_valid, acc_count, acc_sum);
    end
  endtask

  task automatic test_zero_term();
    in_valid = 1; in_last = 1; prod = 8'd0;
    step();
    in_valid = 0; in_last = 0;
    checks++;
    if (out_valid !== 1'b1 || acc_sum !== 12'd0 || acc_count !== 6'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_term: got v=%b sum=%0d cnt=%0d ovf=%b want 1/0/1/0",
               out_valid, acc_sum, acc_count, overflow);
    end
    // Reset while holding a result drops it without a handshake.
    rst_n = 0; step(); rst_n = 1;
    checks++;
    if (out_valid !== 1'b0 || acc_count !== 6'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_done: got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid, acc_count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_short_burst();
    test_saturation();
    test_backpressure();
    test_reset_mid_burst();
    test_ignored_last();
    test_zero_term();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12: accumulator/sum width in bits.
REQ-002 SHALL have parameter MAX_TERMS, default 32: maximum products per burst.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port prod  input  8  unsigned 4x4 product from the upstream array multiplier (0..225).
REQ-006 SHALL have port in_valid  input  1  prod and in_last are valid this cycle.
REQ-007 SHALL have port in_last  input  1  the accepted product closes the current burst.
REQ-008 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-009 SHALL have port acc_sum  output  ACC_W  saturated burst sum.
REQ-010 SHALL have port acc_count  output  6  number of products in the burst (1..MAX_TERMS).
REQ-011 SHALL have port overflow  output  1  sticky flag: the burst saturated.
REQ-012 SHALL have port out_valid  output  1  result on acc_sum/acc_count/overflow is valid.
REQ-013 SHALL have port out_ready  input  1  downstream takes the result.

Function
REQ-014 SHALL implement states IDLE (no terms), ACCUM (>=1 term), DONE (result held).
REQ-015 SHALL drive in_ready = 1 in IDLE/ACCUM and 0 in DONE, decoded from state only.
REQ-016 SHALL accept a product when in_valid && in_ready; no acceptance otherwise.
REQ-017 On accept, SHALL update acc_sum <= min(acc_sum + prod, 2^ACC_W-1), zero-extending prod, and acc_count <= acc_count+1.
REQ-018 SHALL set overflow when the unsaturated sum exceeds 2^ACC_W-1; overflow SHALL stay set until the result is taken.
REQ-019 On accept in IDLE without close, SHALL go to ACCUM.
REQ-020 On accept with in_last=1, or when the accept makes acc_count equal MAX_TERMS, SHALL go to DONE (from IDLE or ACCUM).
REQ-021 SHALL assert out_valid exactly while in DONE; result visible the cycle after the closing accept (latency 1).
REQ-022 In DONE, acc_sum, acc_count and overflow SHALL stay stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready, SHALL clear acc_sum, acc_count and overflow and go to IDLE; one-cycle input bubble follows, and a product offered in that DONE cycle is not accepted.
REQ-024 in_last with in_valid=0 SHALL be ignored.
REQ-025 A zero product SHALL count as a term.

Reset
REQ-026 On rising clk with rst_n=0, SHALL go to IDLE with acc_sum=0, acc_count=0, overflow=0, out_valid=0, in_ready=1 after release.
REQ-027 Reset mid-burst or in DONE SHALL discard the partial/held result with no output handshake.

Structure
REQ-028 Package prod_acc_pkg SHALL hold the state enum, ACC_W/MAX_TERMS defaults and CNT_W=6.
REQ-029 SHALL instantiate one sub-module, sat_adder (ACC_W-bit saturating add, sum plus overflow out); the rest SHALL be flat.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles -> out_valid=0, acc_sum=0, acc_count=0, overflow=0; in_ready=1 after release.
REQ-031 Short burst: prod 225, 10, 1 (last on 3rd) -> next cycle out_valid=1, acc_sum=236, acc_count=3, overflow=0.
REQ-032 Saturation/max terms: 32 x prod=225, no in_last -> 19th accept saturates (4050+225); after 32nd, acc_sum=4095, acc_count=32, overflow=1, out_valid=1.
REQ-033 Backpressure: in DONE, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next cycle IDLE, outputs 0, in_ready=1.
REQ-034 Reset mid-burst: accept 25, 25, then rst_n=0 one edge -> acc_sum=0, acc_count=0, out_valid=0, state IDLE.
REQ-035 Single zero term: prod=0 with in_last=1 from IDLE -> out_valid=1, acc_sum=0, acc_count=1, overflow=0.
